// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a host word stream into instruction memory through the
// IF-stage write port. The fetch pipeline stays stalled during the load, is then
// flushed for FLUSH_CYCLES cycles, and the core is released.
module imem_boot_ctrl #(
  parameter int RV32I_IMEM_DEPTH = 1024,
  parameter int FLUSH_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] base_i,
  input  logic [31:0] len_i,
  input  logic        run_i,
  input  logic        abort_i,
  input  logic        wdata_valid_i,
  input  logic [31:0] wdata_i,
  output logic        wdata_ready_o,
  output logic        imem_wr_en_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        cpu_stall_o,
  output logic        cpu_flush_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;

  // Wide enough to count 0 .. FLUSH_CYCLES-1.
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [31:0]   base_q, len_q, cnt_q;
  logic [FW-1:0] flush_cnt_q;
  logic          wr_en_q, done_q, err_q;
  logic [31:0]   addr_q, data_q;

  logic          start_state, range_bad, start_accept;
  logic          beat, last_beat, flush_last;

  // A load request is only honoured while the core is idle or running.
  assign start_state  = (state == S_IDLE) || (state == S_RUN);
  // 33-bit sum so that base+len cannot wrap past the depth check.
  assign range_bad    = (len_i == 32'd0) ||
                        (({1'b0, base_i} + {1'b0, len_i}) > 33'(RV32I_IMEM_DEPTH));
  assign start_accept = start_state && start_i && !range_bad;
  // Ready is a pure state decode, so a beat is valid while loading; abort drops it.
  assign beat         = (state == S_LOAD) && wdata_valid_i && !abort_i;
  assign last_beat    = beat && (cnt_q == len_q - 32'd1);
  assign flush_last   = (state == S_FLUSH) && (flush_cnt_q == FW'(FLUSH_CYCLES - 1));

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start beats run, abort beats everything in LOAD/FLUSH.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (which would infer a latch).
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start_i)    state_nxt = start_accept ? S_LOAD : S_IDLE;
        else if (run_i) state_nxt = S_FLUSH;
      end
      S_LOAD: begin
        if (abort_i)        state_nxt = S_IDLE;
        else if (last_beat) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (abort_i)         state_nxt = S_IDLE;
        else if (flush_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (start_accept) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    wdata_ready_o = 1'b0;
    busy_o        = 1'b0;
    cpu_flush_o   = 1'b0;
    cpu_stall_o   = 1'b1;
    unique case (state)
      S_LOAD:  begin wdata_ready_o = 1'b1; busy_o = 1'b1; end
      S_FLUSH: cpu_flush_o = 1'b1;
      S_RUN:   cpu_stall_o = 1'b0;
      default: ;
    endcase
  end

  // Load bookkeeping: latched window, beat counter and flush timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (start_accept) begin
        base_q <= base_i;
        len_q  <= len_i;
      end
      if (state != S_LOAD || last_beat) cnt_q <= '0;
      else if (beat)                    cnt_q <= cnt_q + 32'd1;
      if (state == S_FLUSH) flush_cnt_q <= flush_cnt_q + FW'(1);
      else                  flush_cnt_q <= '0;
    end
  end

  // Registered IMEM write port (one cycle after the beat) and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= beat;
      if (beat) begin
        addr_q <= base_q + cnt_q;
        data_q <= wdata_i;
      end
      done_q <= flush_last && !abort_i;
      err_q  <= start_state && start_i && range_bad;
    end
  end

  assign imem_wr_en_o = wr_en_q;
  assign imem_addr_o  = addr_q;
  assign imem_data_o  = data_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl: directed steps, with every expected IMEM
// write pushed to a scoreboard queue and matched by a write monitor.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, run_i, abort_i, wdata_valid_i;
  logic [31:0] base_i, len_i, wdata_i;
  logic        wdata_ready_o, imem_wr_en_o, cpu_stall_o, cpu_flush_o;
  logic        busy_o, done_o, err_o;
  logic [31:0] imem_addr_o, imem_data_o;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;

  imem_boot_ctrl #(.RV32I_IMEM_DEPTH(1024), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .run_i(run_i), .abort_i(abort_i),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .imem_wr_en_o(imem_wr_en_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .cpu_stall_o(cpu_stall_o), .cpu_flush_o(cpu_flush_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done_o && k < 10) begin
      tick();
      k++;
    end
    check(tag, 32'(done_o), 32'd1);
  endtask

  // Write monitor: every IMEM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_wr_en_o) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", imem_addr_o, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", imem_addr_o, e.addr);
          check("wr_data", imem_data_o, e.data);
        end
      end
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
    end
  end

  initial begin
    int wr0, done0;
    rst_n = 1'b0; start_i = 1'b0; run_i = 1'b0; abort_i = 1'b0;
    wdata_valid_i = 1'b0; base_i = '0; len_i = '0; wdata_i = '0;

    // T1: reset state
    #12;
    check("rst_stall", 32'(cpu_stall_o), 32'd1);
    check("rst_ready", 32'(wdata_ready_o), 32'd0);
    check("rst_wr_en", 32'(imem_wr_en_o), 32'd0);
    check("rst_flush", 32'(cpu_flush_o), 32'd0);
    check("rst_done",  32'(done_o), 32'd0);
    check("rst_err",   32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T2: base 0x10 len 4, valid held high
    wr0 = wr_cnt;
    start_i = 1'b1; base_i = 32'h10; len_i = 32'd4;
    tick();
    start_i = 1'b0;
    check("t2_busy",  32'(busy_o), 32'd1);
    check("t2_ready", 32'(wdata_ready_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wdata_valid_i = 1'b1;
      wdata_i = 32'hA0A0_0000 + 32'(i);
      exp_q.push_back('{addr: 32'h10 + 32'(i), data: wdata_i});
      tick();
      if (i == 0) begin
        check("t2_lat_wr_en", 32'(imem_wr_en_o), 32'd1);
        check("t2_lat_addr",  imem_addr_o, 32'h10);
      end
    end
    wdata_valid_i = 1'b0;
    check("t2_ready_drop", 32'(wdata_ready_o), 32'd0);
    check("t2_flush1", 32'(cpu_flush_o), 32'd1);
    check("t2_stall_f", 32'(cpu_stall_o), 32'd1);
    tick();
    check("t2_flush2", 32'(cpu_flush_o), 32'd1);
    check("t2_done_early", 32'(done_o), 32'd0);
    tick();
    check("t2_flush_off", 32'(cpu_flush_o), 32'd0);
    check("t2_done", 32'(done_o), 32'd1);
    check("t2_stall_run", 32'(cpu_stall_o), 32'd0);
    tick();
    check("t2_done_pulse", 32'(done_o), 32'd0);
    check("t2_nwr", 32'(wr_cnt - wr0), 32'd4);

    // T3: len 3 with valid toggling (start from RUN stops fetch)
    wr0 = wr_cnt;
    start_i = 1'b1; base_i = 32'h100; len_i = 32'd3;
    tick();
    start_i = 1'b0;
    check("t3_stall", 32'(cpu_stall_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wdata_valid_i = (i % 2 == 0);
      wdata_i = 32'hC3C3_0000 + 32'(i);
      if (wdata_valid_i)
        exp_q.push_back('{addr: 32'h100 + 32'(i / 2), data: wdata_i});
      tick();
    end
    wdata_valid_i = 1'b0;
    wait_done("t3_done");
    tick();
    check("t3_nwr", 32'(wr_cnt - wr0), 32'd3);

    // T4: range errors from RUN: len 0, 1020+8 > 1024, 33-bit overflow
    wr0 = wr_cnt;
    start_i = 1'b1; base_i = 32'd0; len_i = 32'd0;
    tick();
    start_i = 1'b0;
    check("t4_err_len0", 32'(err_o), 32'd1);
    check("t4_stay_run", 32'(cpu_stall_o), 32'd0);
    tick();
    check("t4_err_pulse", 32'(err_o), 32'd0);
    start_i = 1'b1; base_i = 32'd1020; len_i = 32'd8;
    tick();
    start_i = 1'b0;
    check("t4_err_range", 32'(err_o), 32'd1);
    check("t4_not_busy", 32'(busy_o), 32'd0);
    start_i = 1'b1; base_i = 32'hFFFF_FFFF; len_i = 32'd2;
    tick();
    start_i = 1'b0;
    check("t4_err_wrap", 32'(err_o), 32'd1);
    tick();
    check("t4_nwr", 32'(wr_cnt - wr0), 32'd0);

    // T5: abort after 2 of 5 beats (enter IDLE first through a reset)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr0 = wr_cnt; done0 = done_cnt;
    start_i = 1'b1; base_i = 32'h200; len_i = 32'd5;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata_valid_i = 1'b1;
      wdata_i = 32'h5A5A_0000 + 32'(i);
      exp_q.push_back('{addr: 32'h200 + 32'(i), data: wdata_i});
      tick();
    end
    wdata_valid_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5_stall", 32'(cpu_stall_o), 32'd1);
    check("t5_idle", 32'(busy_o), 32'd0);
    check("t5_ready", 32'(wdata_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t5_nwr", 32'(wr_cnt - wr0), 32'd2);
    check("t5_no_done", 32'(done_cnt - done0), 32'd0);

    // T6: run_i from IDLE, then start in RUN at the top boundary 1020+4
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    check("t6_flush1", 32'(cpu_flush_o), 32'd1);
    tick();
    check("t6_flush2", 32'(cpu_flush_o), 32'd1);
    tick();
    check("t6_done", 32'(done_o), 32'd1);
    check("t6_stall_run", 32'(cpu_stall_o), 32'd0);
    tick();
    wr0 = wr_cnt;
    start_i = 1'b1; base_i = 32'd1020; len_i = 32'd4;
    tick();
    start_i = 1'b0;
    check("t6_stall_next", 32'(cpu_stall_o), 32'd1);
    check("t6_no_err", 32'(err_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      wdata_valid_i = 1'b1;
      wdata_i = 32'hE7E7_0000 + 32'(i);
      exp_q.push_back('{addr: 32'd1020 + 32'(i), data: wdata_i});
      tick();
    end
    wdata_valid_i = 1'b0;
    wait_done("t6_load_done");
    tick();
    check("t6_nwr", 32'(wr_cnt - wr0), 32'd4);

    // Reset in the middle of a load keeps the core stalled
    start_i = 1'b1; base_i = 32'h40; len_i = 32'd8;
    tick();
    start_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", 32'(cpu_stall_o), 32'd1);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_wr_en", 32'(imem_wr_en_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("total_done", 32'(done_cnt), 32'd4);
    check("total_err", 32'(err_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
